// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared types and constants for the DDR user-port arbiter
package ddr_arb_pkg;

  localparam int DDR_ADDR_W = 27;
  localparam int DDR_DATA_W = 128;
  localparam int DDR_BE_W   = 8;

  localparam logic [1:0] MEM_EN_IDLE  = 2'b00;
  localparam logic [1:0] MEM_EN_READ  = 2'b01;
  localparam logic [1:0] MEM_EN_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// rtl/ddr_port_arbiter_if.sv - DDR user command port bundle
interface ddr_port_arbiter_if;
  import ddr_arb_pkg::*;

  logic [DDR_ADDR_W-1:0] mem_address;
  logic [DDR_DATA_W-1:0] mem_write_data;
  logic [DDR_BE_W-1:0]   mem_write_bytes;
  logic [1:0]            mem_enable;
  logic                  mem_new_command;
  logic [3:0]            mem_ready;
  logic [DDR_DATA_W-1:0] mem_read_data;
  logic                  mem_finished_command;

  modport master (
    output mem_address, mem_write_data, mem_write_bytes, mem_enable, mem_new_command,
    input  mem_ready, mem_read_data, mem_finished_command
  );

  modport slave (
    input  mem_address, mem_write_data, mem_write_bytes, mem_enable, mem_new_command,
    output mem_ready, mem_read_data, mem_finished_command
  );

endinterface

// File: rtl/ddr_rr_picker.sv
// rtl/ddr_rr_picker.sv - combinational round-robin picker, first request at or after ptr
module ddr_rr_picker #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          found
);

  logic [2*N-1:0] rot_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   low;
  logic [2*N-1:0] back_dbl;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_dbl  = {req, req} >> ptr;
    rot      = rot_dbl[N-1:0];
    low      = rot & (~rot + 1'b1);
    back_dbl = {low, low} << ptr;
    grant    = back_dbl[2*N-1:N];
    found    = |req;
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - shares the DDR user command port among NUM_REQ requesters
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int         NUM_REQ        = 3,
  parameter logic [7:0] PRIO_MASK      = 8'h01,
  parameter int         STARVE_LIMIT   = 8,
  parameter int         TIMEOUT_CYCLES = 4096,
  localparam int        GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             ram_init_done,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*DDR_ADDR_W-1:0]    req_address,
  input  logic [NUM_REQ*DDR_DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*DDR_BE_W-1:0]      req_wbytes,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DDR_DATA_W-1:0]            rsp_rdata,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy,
  output logic                             timeout_error,
  ddr_port_arbiter_if.master               mem
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] HI_MASK = PRIO_MASK[NUM_REQ-1:0];
  localparam logic [NUM_REQ-1:0] LO_MASK = ~HI_MASK;

  arb_state_e            state;
  logic [GW-1:0]         hi_ptr, lo_ptr;
  logic [SW-1:0]         starve_cnt [NUM_REQ];
  logic [TW-1:0]         wd_cnt;
  logic                  write_q;
  logic [NUM_REQ-1:0]    grant_oh;

  logic [NUM_REQ-1:0]    hi_grant, lo_grant, starve_hit, starve_grant, win_oh;
  logic                  hi_found, lo_found, can_issue;
  logic [GW-1:0]         win_idx, next_ptr;
  logic [DDR_ADDR_W-1:0] sel_addr;
  logic [DDR_DATA_W-1:0] sel_data;
  logic [DDR_BE_W-1:0]   sel_be;
  logic                  sel_write;
  logic                  unused_mem_ready;

  assign unused_mem_ready = &{1'b0, mem.mem_ready[3:1]};
  assign busy = (state != IDLE);

  ddr_rr_picker #(.N(NUM_REQ), .PW(GW)) u_hi_pick (
    .req(req_valid & HI_MASK), .ptr(hi_ptr), .grant(hi_grant), .found(hi_found)
  );

  ddr_rr_picker #(.N(NUM_REQ), .PW(GW)) u_lo_pick (
    .req(req_valid & LO_MASK), .ptr(lo_ptr), .grant(lo_grant), .found(lo_found)
  );

  // Winner selection: starved low-prio first, then high class, then low class.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starve_hit[i] = LO_MASK[i] & req_valid[i] & (starve_cnt[i] == SW'(STARVE_LIMIT));
    end
    starve_grant = starve_hit & (~starve_hit + 1'b1);
    if (|starve_hit)   win_oh = starve_grant;
    else if (hi_found) win_oh = hi_grant;
    else               win_oh = lo_grant;
    can_issue = ram_init_done & mem.mem_ready[0] & ~mem.mem_finished_command & (hi_found | lo_found);
    next_ptr  = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Payload and index of the winner.
  always_comb begin
    win_idx   = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_be    = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx   = i[GW-1:0];
        sel_addr  = req_address[DDR_ADDR_W*i +: DDR_ADDR_W];
        sel_data  = req_wdata[DDR_DATA_W*i +: DDR_DATA_W];
        sel_be    = req_wbytes[DDR_BE_W*i +: DDR_BE_W];
        sel_write = req_write[i];
      end
    end
  end

  // Command sequencer: IDLE -> ISSUE -> WAIT -> RESP, all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                <= IDLE;
      hi_ptr               <= '0;
      lo_ptr               <= '0;
      wd_cnt               <= '0;
      write_q              <= 1'b0;
      grant_oh             <= '0;
      grant_id             <= '0;
      req_ready            <= '0;
      rsp_valid            <= '0;
      rsp_rdata            <= '0;
      timeout_error        <= 1'b0;
      mem.mem_address      <= '0;
      mem.mem_write_data   <= '0;
      mem.mem_write_bytes  <= '0;
      mem.mem_enable       <= MEM_EN_IDLE;
      mem.mem_new_command  <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (can_issue) begin
            mem.mem_address     <= sel_addr;
            mem.mem_write_data  <= sel_data;
            mem.mem_write_bytes <= sel_be;
            write_q             <= sel_write;
            req_ready           <= win_oh;
            grant_oh            <= win_oh;
            grant_id            <= win_idx;
            state               <= ISSUE;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (win_oh[i])
                starve_cnt[i] <= '0;
              else if (LO_MASK[i] && req_valid[i] && starve_cnt[i] != SW'(STARVE_LIMIT))
                starve_cnt[i] <= starve_cnt[i] + 1'b1;
            end
          end
        end
        ISSUE: begin
          mem.mem_new_command <= 1'b1;
          mem.mem_enable      <= write_q ? MEM_EN_WRITE : MEM_EN_READ;
          wd_cnt              <= '0;
          state               <= WAIT;
        end
        WAIT: begin
          mem.mem_new_command <= 1'b0;
          if (mem.mem_finished_command) begin
            rsp_rdata      <= write_q ? '0 : mem.mem_read_data;
            rsp_valid      <= grant_oh;
            mem.mem_enable <= MEM_EN_IDLE;
            state          <= RESP;
          end else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_error  <= 1'b1;
            rsp_rdata      <= '0;
            rsp_valid      <= grant_oh;
            mem.mem_enable <= MEM_EN_IDLE;
            state          <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (|(grant_oh & HI_MASK)) hi_ptr <= next_ptr;
          else                       lo_ptr <= next_ptr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - directed self-checking bench for ddr_port_arbiter
module tb_ddr_port_arbiter;
  import ddr_arb_pkg::*;

  localparam int N = 3;
  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_B  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, ram_init_done;
  logic [N-1:0]       req_valid, req_write, req_ready, rsp_valid;
  logic [N*27-1:0]    req_address;
  logic [N*128-1:0]   req_wdata;
  logic [N*8-1:0]     req_wbytes;
  logic [127:0]       rsp_rdata;
  logic [1:0]         grant_id;
  logic               busy, timeout_error;

  ddr_port_arbiter_if mif();

  ddr_port_arbiter #(.NUM_REQ(N), .PRIO_MASK(8'h01), .STARVE_LIMIT(8), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .reset_n(reset_n), .ram_init_done(ram_init_done),
    .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
    .req_wdata(req_wdata), .req_wbytes(req_wbytes), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .grant_id(grant_id),
    .busy(busy), .timeout_error(timeout_error), .mem(mif)
  );

  // Memory model: finishes mem_delay cycles after new_command, holds finished 3 cycles.
  int           mem_delay = 10;
  bit           mem_never = 1'b0;
  logic         fin_force = 1'b0;
  logic [127:0] mem_rdata_v = PAT_A5;
  logic         model_fin = 1'b0;
  int           model_cnt = 0;
  int           hold_cnt = 0;

  assign mif.mem_ready            = 4'b0001;
  assign mif.mem_read_data        = mem_rdata_v;
  assign mif.mem_finished_command = model_fin | fin_force;

  always @(negedge clk) begin
    if (mif.mem_new_command) begin
      if (!mem_never) model_cnt = mem_delay;
    end else if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) begin
        model_fin = 1'b1;
        hold_cnt  = 3;
      end
    end else if (hold_cnt > 0) begin
      hold_cnt = hold_cnt - 1;
      if (hold_cnt == 0) model_fin = 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Results captured by run_cmd.
  logic [N-1:0] c_ready, c_rv;
  logic [1:0]   c_gid, c_en;
  logic         c_nc;
  logic [26:0]  c_addr;
  logic [127:0] c_data, c_rdata;
  logic [7:0]   c_be;
  bit           c_stable;
  int           c_lat;
  int           glog[$];

  task automatic run_cmd(input int r, input bit wr, input logic [26:0] a,
                         input logic [127:0] d, input logic [7:0] be, input int bound);
    int k;
    req_write[r] = wr;
    req_address[27*r +: 27] = a;
    req_wdata[128*r +: 128] = d;
    req_wbytes[8*r +: 8] = be;
    req_valid[r] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (req_ready == '0 && k < 100);
    c_ready = req_ready;
    c_gid   = grant_id;
    req_valid[r] = 1'b0;
    @(negedge clk);
    c_nc   = mif.mem_new_command;
    c_en   = mif.mem_enable;
    c_addr = mif.mem_address;
    c_data = mif.mem_write_data;
    c_be   = mif.mem_write_bytes;
    c_stable = 1'b1;
    c_lat = 0;
    while (c_lat < bound) begin
      @(negedge clk);
      c_lat++;
      if (rsp_valid != '0) break;
      if (mif.mem_new_command || mif.mem_enable !== c_en || mif.mem_address !== c_addr ||
          mif.mem_write_data !== c_data || mif.mem_write_bytes !== c_be) c_stable = 1'b0;
    end
    c_rv    = rsp_valid;
    c_rdata = rsp_rdata;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || mif.mem_finished_command) && k < 200) begin @(negedge clk); k++; end
    check_val(tag, k < 200, 1'b1);
  endtask

  task automatic collect_grants(input int n, input int bound);
    int k;
    glog.delete();
    k = 0;
    while (glog.size() < n && k < bound) begin
      @(negedge clk);
      k++;
      for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
      if (glog.size() >= n) req_valid = '0;
    end
    req_valid = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int k, seen_ready, seen_rsp;
    int exp2 [6] = '{2, 1, 2, 1, 2, 1};
    reset_n = 1'b0; ram_init_done = 1'b0;
    req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0; req_wbytes = '0;
    do_reset();

    check_val("rst req_ready", req_ready, 0);
    check_val("rst rsp_valid", rsp_valid, 0);
    check_val("rst new_cmd", mif.mem_new_command, 0);
    check_val("rst enable", mif.mem_enable, 0);
    check_val("rst busy", busy, 0);
    check_val("rst timeout", timeout_error, 0);
    check_val("rst grant_id", grant_id, 0);

    // No command while ram_init_done is low.
    req_valid[1] = 1'b1;
    seen_ready = 0;
    repeat (10) begin @(negedge clk); if (req_ready != '0) seen_ready++; end
    check_val("init gate ready", seen_ready, 0);
    check_val("init gate busy", busy, 0);
    req_valid = '0;
    ram_init_done = 1'b1;
    @(negedge clk);

    // 1: single read.
    mem_delay = 10; mem_rdata_v = PAT_A5;
    run_cmd(1, 1'b0, 27'h0001000, '0, '0, 50);
    check_val("t1 ready", c_ready, 3'b010);
    check_val("t1 grant_id", c_gid, 1);
    check_val("t1 new_cmd", c_nc, 1);
    check_val("t1 enable", c_en, MEM_EN_READ);
    check_val("t1 addr", c_addr, 27'h0001000);
    check_val("t1 latency", c_lat, 11);
    check_val("t1 rsp_valid", c_rv, 3'b010);
    check_val("t1 rdata", c_rdata, PAT_A5);
    check_val("t1 resp enable", mif.mem_enable, MEM_EN_IDLE);
    wait_idle("t1 idle");

    // 2: two low-prio requesters alternate (lo pointer left at 2 by test 1).
    mem_delay = 2;
    req_valid = 3'b110;
    collect_grants(6, 400);
    check_val("t2 count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      check_val($sformatf("t2 grant%0d", i), glog[i], exp2[i]);
    wait_idle("t2 idle");

    // 3: high-prio req0 vs low-prio req2, starvation override every 9th grant.
    do_reset();
    mem_delay = 1;
    req_valid = 3'b101;
    collect_grants(18, 1000);
    check_val("t3 count", glog.size(), 18);
    for (int i = 0; i < 18 && i < glog.size(); i++)
      check_val($sformatf("t3 grant%0d", i), glog[i], (i == 8 || i == 17) ? 2 : 0);
    wait_idle("t3 idle");

    // 4: write, payload stable through WAIT, response data zero.
    mem_delay = 6; mem_rdata_v = PAT_A5;
    run_cmd(1, 1'b1, 27'h7FFFFF0, {4{32'hDEADBEEF}}, 8'h0F, 50);
    check_val("t4 enable", c_en, MEM_EN_WRITE);
    check_val("t4 bytes", c_be, 8'h0F);
    check_val("t4 addr", c_addr, 27'h7FFFFF0);
    check_val("t4 data", c_data, {4{32'hDEADBEEF}});
    check_val("t4 stable", c_stable, 1);
    check_val("t4 rsp_valid", c_rv, 3'b010);
    check_val("t4 rdata", c_rdata, 0);
    wait_idle("t4 idle");

    // 5: lost command hits the watchdog, next request still served.
    mem_never = 1'b1;
    check_val("t5 timeout pre", timeout_error, 0);
    run_cmd(2, 1'b0, 27'h0000040, '0, '0, 5000);
    check_val("t5 latency", c_lat, 4096);
    check_val("t5 rsp_valid", c_rv, 3'b100);
    check_val("t5 rdata", c_rdata, 0);
    check_val("t5 timeout", timeout_error, 1);
    mem_never = 1'b0; mem_delay = 3; mem_rdata_v = PAT_B;
    run_cmd(0, 1'b0, 27'h0000080, '0, '0, 50);
    check_val("t5 next rsp", c_rv, 3'b001);
    check_val("t5 next rdata", c_rdata, PAT_B);
    check_val("t5 sticky", timeout_error, 1);
    wait_idle("t5 idle");

    // 6: reset during WAIT, late finished must be absorbed.
    mem_never = 1'b1;
    req_valid[1] = 1'b1;
    k = 0;
    while (!mif.mem_new_command && k < 50) begin @(negedge clk); k++; end
    check_val("t6 issued", k < 50, 1);
    req_valid = '0;
    repeat (3) @(negedge clk);
    do_reset();
    mem_never = 1'b0;
    check_val("t6 busy after rst", busy, 0);
    check_val("t6 timeout cleared", timeout_error, 0);
    seen_ready = 0; seen_rsp = 0;
    repeat (2) begin
      @(negedge clk);
      if (req_ready != '0) seen_ready++;
      if (rsp_valid != '0) seen_rsp++;
    end
    fin_force = 1'b1;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_address[26:0] = 27'h0000100;
    repeat (5) begin
      @(negedge clk);
      if (req_ready != '0) seen_ready++;
      if (rsp_valid != '0) seen_rsp++;
    end
    fin_force = 1'b0;
    check_val("t6 held while finished", seen_ready, 0);
    k = 0;
    do begin @(negedge clk); k++; if (rsp_valid != '0) seen_rsp++; end
      while (req_ready == '0 && k < 20);
    check_val("t6 ready after drop", req_ready, 3'b001);
    check_val("t6 no stale rsp", seen_rsp, 0);
    req_valid = '0;
    k = 0;
    while (rsp_valid == '0 && k < 50) begin @(negedge clk); k++; end
    check_val("t6 served rsp", rsp_valid, 3'b001);
    check_val("t6 served rdata", rsp_rdata, PAT_B);
    wait_idle("t6 idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
